// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encodings,
// the default reset PC, instruction field bit positions and a small
// helper for the branch offset.
package ifu_pkg;

    // Default PC loaded on reset (word aligned)
    localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;

    // FSM state encodings
    localparam logic [1:0] IFU_IDLE  = 2'd0;
    localparam logic [1:0] IFU_FETCH = 2'd1;
    localparam logic [1:0] IFU_ISSUE = 2'd2;

    // Instruction field bit positions
    localparam int OP_HI      = 31;
    localparam int OP_LO      = 26;
    localparam int RS_HI      = 25;
    localparam int RS_LO      = 21;
    localparam int RT_HI      = 20;
    localparam int RT_LO      = 16;
    localparam int RD_HI      = 15;
    localparam int RD_LO      = 11;
    localparam int FUNCT_HI   = 5;
    localparam int FUNCT_LO   = 0;
    localparam int IMM_HI     = 15;
    localparam int IMM_LO     = 0;
    localparam int JTARGET_HI = 25;
    localparam int JTARGET_LO = 0;

    // Sign-extend a 16-bit immediate and scale it to a byte offset
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/ifu_npc.sv
// Next-PC selection: jump target, taken branch or fall-through.
// Purely combinational; the caller decides when the result is committed.
module ifu_npc (
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] next_pc
);
    import ifu_pkg::*;

    // The opcode field plays no part in target computation
    logic unused_op_bits;
    assign unused_op_bits = ^instr[OP_HI:OP_LO];

    // Jump wins over branch; a branch is taken only when the ALU reports zero
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr[JTARGET_HI:JTARGET_LO], 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_offset(instr[IMM_HI:IMM_LO]);
        end
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ready
// handshake, holds the instruction register for decode and commits the
// next PC when the datapath acknowledges the instruction.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero,
    output logic [31:0] instr,
    output logic [5:0]  OP,
    output logic [5:0]  Funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] pc_plus4_w;
    logic [31:0] next_pc_w;

    assign pc_plus4_w = pc_q + 32'd4;

    ifu_npc u_npc (
        .pc_plus4 (pc_plus4_w),
        .instr    (instr_q),
        .branch   (Branch),
        .jump     (Jump),
        .zero     (Zero),
        .next_pc  (next_pc_w)
    );

    // FSM: IDLE -> FETCH (wait for ready) -> ISSUE (wait for ack) -> FETCH
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        case (state_q)
            IFU_IDLE: begin
                state_d = IFU_FETCH;
            end
            IFU_FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = IFU_ISSUE;
                end
            end
            IFU_ISSUE: begin
                if (instr_ack) begin
                    pc_d      = next_pc_w;
                    retired_d = retired_q + 32'd1;
                    state_d   = IFU_FETCH;
                end
            end
            default: begin
                state_d = IFU_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IFU_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    assign imem_req    = (state_q == IFU_FETCH);
    assign imem_addr   = {pc_q[31:2], 2'b00};
    assign instr_valid = (state_q == IFU_ISSUE);

    assign instr    = instr_q;
    assign OP       = instr_q[OP_HI:OP_LO];
    assign Funct    = instr_q[FUNCT_HI:FUNCT_LO];
    assign rs       = instr_q[RS_HI:RS_LO];
    assign rt       = instr_q[RT_HI:RT_LO];
    assign rd       = instr_q[RD_HI:RD_LO];
    assign imm16    = instr_q[IMM_HI:IMM_LO];
    assign pc       = pc_q;
    assign pc_plus4 = pc_plus4_w;
    assign retired  = retired_q;

endmodule

// File: doc/ifu.md
Name: ifu

Overview:
Instruction fetch unit: the producer side of the decode interface. It owns the PC, fetches instruction words over a req/ready handshake to instruction memory, and presents a held instruction register split into fields (OP, Funct, rs, rt, rd, imm16). It consumes Branch/Jump from the controller and Zero from the ALU to compute the next PC when the datapath retires the instruction. Sits between instruction memory and ctrl/datapath in the CPU top.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
imem_req  out  1  fetch request, asserted in FETCH state
imem_addr  out  32  fetch address = pc with [1:0] forced to 0
imem_ready  in  1  memory response valid this cycle (rdata valid)
imem_rdata  in  32  fetched instruction word
instr_valid  out  1  IR holds a valid instruction (ISSUE state)
instr_ack  in  1  datapath has executed the instruction; commit next PC
Branch  in  1  from ctrl
Jump  in  1  from ctrl
Zero  in  1  from ALU
instr  out  32  instruction register
OP  out  6  instr[31:26]
Funct  out  6  instr[5:0]
rs  out  5  instr[25:21]
rt  out  5  instr[20:16]
rd  out  5  instr[15:11]
imm16  out  16  instr[15:0]
pc  out  32  address of the instruction in IR
pc_plus4  out  32  pc+4, link value for JAL
retired  out  32  count of acked instructions, wraps modulo 2^32

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, pc=RESET_PC, instr=0 (decodes as NOP/default), retired=0. During IDLE: imem_req=0, instr_valid=0.
- States: IDLE -> FETCH unconditionally, one cycle after reset releases.
- FETCH: imem_req=1, imem_addr=pc. On imem_ready=1: instr<=imem_rdata, -> ISSUE. Otherwise hold and keep requesting; wait is unbounded. instr_ack ignored.
- ISSUE: instr_valid=1, IR and pc stable. On instr_ack=1: pc<=next_pc, retired<=retired+1, -> FETCH. imem_ready ignored.
- Minimum latency: 1 cycle FETCH (ready same cycle) + 1 cycle ISSUE = 2 cycles per instruction.
- next_pc, sampled on the ack cycle:
  - Jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}. Jump takes priority over Branch when both are high.
  - else Branch=1 and Zero=1: pc_plus4 + (sign_extend(imm16) << 2).
  - else pc_plus4.
- All PC arithmetic is 32-bit modulo. pc=32'hFFFF_FFFC sequential gives 0.
- Field outputs are pure slices of instr, combinational from the register.
- Reset mid-operation, in any state: return to IDLE next edge. A memory response arriving while in IDLE is dropped.
- Reset is never recorded as a retired instruction.
- pc[1:0] is always 0.

Decomposition:
- instr_def.v gains the field bit positions (OP_HI/LO, RS, RT, RD, FUNCT, IMM, JTARGET).
- A new ifu_def.v holds state encodings IFU_IDLE=2'd0, IFU_FETCH=2'd1, IFU_ISSUE=2'd2 and the default RESET_PC.
- One combinational sub-module, npc, takes pc_plus4, instr, Branch, Jump and Zero, and outputs next_pc. The FSM, PC, IR and counter stay in ifu.

Test Plan:
- Reset held 3 cycles, then released -> imem_req=0 in cycle 1, then imem_req=1 with imem_addr=32'h3000. retired=0, instr=0.
- Fetch words 32'h0000_0021 (addu), then ready with 0-cycle delay and ack each -> addresses 3000, 3004, 3008. retired increments to 3. OP=0, Funct=6'h21.
- imem_ready delayed 3 cycles -> imem_req held high with a stable address. instr_valid stays 0 until the cycle after ready.
- beq with imm16=16'hFFFE at pc=3010, Branch=1, Zero=1 on ack -> next fetch at 32'h300C. Same with Zero=0 -> fetch at 32'h3014.
- jal word 32'h0C00_0C10 at pc=3020, Jump=1 (Branch=1 also driven) -> pc_plus4=3024, next fetch at 32'h0000_3040.
- Reset asserted in FETCH while imem_ready arrives the same cycle -> instr stays 0, state IDLE, pc=3000, retired=0.
